rx_uart: RTL
============

// Module: rx_uart
// PURPOSE
//  Memory-mapped serial receiver, the inbound counterpart of tx_uart on the soc bus.
//  - Deserialises 8N1 frames from rx_line (LSB first) and buffers the received bytes in a small FIFO.
//  - The cpu reads the head byte through the soc read-data mux; that read pops it.
//  - Bit timing is a cycles-per-bit value written over the same config_data/config_enable style as tx_uart.
// PARAMETERS
//  DEFAULT_CPB  8'd104  cycles-per-bit after reset; clamped to 4 if <4
//  FIFO_DEPTH   4       receive FIFO entries; power of two, >=2
// PORTS
//  clk            in   1  system clock, all state on rising edge
//  rst            in   1  asynchronous, active-high reset
//  rx_line        in   1  serial input, idle high, asynchronous to clk
//  config_data    in   8  new cycles-per-bit value
//  config_enable  in   1  load config_data into cpb register this cycle
//  read_enable    in   1  pop FIFO head (cpu read of receive address), 1 cycle
//  read_data      out  8  FIFO head byte, combinational; 8'h00 when empty
//  data_valid     out  1  FIFO not empty
//  overrun        out  1  sticky: completed byte dropped because FIFO full
//  framing_error  out  1  sticky: stop bit sampled low
// BEHAVIOUR
//  Reset:
//  - state=IDLE, cpb=DEFAULT_CPB (clamped), FIFO empty.
//  - data_valid=0, read_data=0, overrun=0, framing_error=0.
//  - Synchroniser flops set to 1.
//  Input path: rx_line passes through a 2-flop synchroniser (sync=rx_s). A falling edge of rx_s is detected
//  against its previous value. Input-to-decision latency is 3 clk.
//  cpb register:
//  - config_enable loads max(config_data,4).
//  - The value is latched into cpb_active on START entry, so a write mid-frame affects the next frame only.
//  Bit timer: 8-bit down counter; a "tick" occurs when it reaches 0, then it reloads.
//  FSM states (IDLE, START, DATA, STOP):
//  - IDLE: on falling edge of rx_s -> START, timer=(cpb_active>>1)-1.
//  - START: on tick, if rx_s==0 -> DATA, timer=cpb_active-1, bit_cnt=0. If rx_s==1 (glitch) -> IDLE, nothing recorded.
//  - DATA: on tick, shift rx_s into bit[bit_cnt] (LSB first) and reload the timer.
//    After the 8th sample -> STOP, timer=cpb_active-1.
//  - STOP: on tick, always -> IDLE.
//    - rx_s==1: push the byte.
//    - rx_s==0: set framing_error, discard the byte.
//  Push latency: data_valid/read_data update on the clock edge after the stop-bit tick.
//  FIFO:
//  - Read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
//  - full = MSBs differ and lower bits equal; empty = pointers equal.
//  - Push when full: byte dropped, overrun=1, contents unchanged.
//  - read_enable when empty: ignored, no pointer change.
//  - Push and pop in the same cycle: pop is applied first, so when full both succeed and there is no overrun.
//    When empty, the push succeeds and the pop is ignored.
//  Sticky flags: overrun and framing_error clear on any cycle with read_enable=1, unless set in that same cycle (set wins).
//  Reset mid-frame: the partial byte is lost and the FSM returns to IDLE. The next falling edge starts a clean frame.
//  A line held low (break) yields at most one framing_error. A new frame needs a fresh falling edge.
// TESTING
//  1 Assert rst mid-cycle -> immediately data_valid=0, read_data=00, overrun=0, framing_error=0.
//  2 cpb=16, send 8N1 byte 0xA5 -> data_valid=1, read_data=A5 within 1 clk of stop tick.
//    Pulse read_enable -> data_valid=0, read_data=00.
//  3 cpb=16, send 0x01..0x05 without reads -> overrun=1.
//    Reads return 01,02,03,04, then data_valid=0.
//  4 Send 0x3C with stop bit=0 -> framing_error=1, data_valid=0.
//    Next read_enable clears the flag.
//  5 rx_line low for 3 clk at cpb=16 -> no push, FSM back in IDLE, flags 0.
//    Then a full frame 0x5A is received correctly.
//  6 Config write cpb=8 mid-frame at cpb=16 -> current byte 0x77 at 16 is correct.
//    Next frame sent at 8 cycles/bit decodes 0x88. Config write of 2 -> cpb=4.

Source files
------------

// File: rtl/rx_uart.sv
// Memory-mapped 8N1 serial receiver: synchronised line sampling, mid-bit timing,
// small receive FIFO popped by cpu reads, sticky overrun/framing flags.
module rx_uart #(
  parameter logic [7:0] DEFAULT_CPB = 8'd104,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  input  logic [7:0] config_data,
  input  logic       config_enable,
  input  logic       read_enable,
  output logic [7:0] read_data,
  output logic       data_valid,
  output logic       overrun,
  output logic       framing_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  function automatic logic [7:0] clamp_cpb(input logic [7:0] v);
    return (v < 8'd4) ? 8'd4 : v;
  endfunction

  state_t        state_q, state_d;
  logic          sync1_q, rx_s_q, rx_prev_q;
  logic [7:0]    timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    cpb_q, cpb_d;
  logic [7:0]    cpb_act_q, cpb_act_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          overrun_q, overrun_d, fe_q, fe_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic fall, tick, push_req, fe_set;
  logic empty, full, do_pop, do_push, ovr_set;

  assign fall = rx_prev_q & ~rx_s_q;
  assign tick = (timer_q == 8'd0);

  // Receive FSM: START waits half a bit to land mid-bit, DATA/STOP wait whole bits
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    cpb_act_d = cpb_act_q;
    push_req  = 1'b0;
    fe_set    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d   = START;
          cpb_act_d = cpb_q;
          timer_d   = (cpb_q >> 1) - 8'd1;
        end
      end
      START: begin
        if (!tick) begin
          timer_d = timer_q - 8'd1;
        end else if (!rx_s_q) begin
          state_d   = DATA;
          timer_d   = cpb_act_q - 8'd1;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!tick) begin
          timer_d = timer_q - 8'd1;
        end else begin
          shift_d[bit_cnt_q] = rx_s_q;
          timer_d            = cpb_act_q - 8'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      STOP: begin
        if (!tick) begin
          timer_d = timer_q - 8'd1;
        end else begin
          state_d  = IDLE;
          push_req = rx_s_q;
          fe_set   = ~rx_s_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO control: a pop frees the slot a same-cycle push needs
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop    = read_enable & ~empty;
    do_push   = push_req & (~full | do_pop);
    ovr_set   = push_req & full & ~do_pop;
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, do_pop};
    overrun_d = ovr_set | (overrun_q & ~read_enable);
    fe_d      = fe_set | (fe_q & ~read_enable);
    cpb_d     = config_enable ? clamp_cpb(config_data) : cpb_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      timer_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
      cpb_q     <= clamp_cpb(DEFAULT_CPB);
      cpb_act_q <= clamp_cpb(DEFAULT_CPB);
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      sync1_q   <= rx_line;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      cpb_q     <= cpb_d;
      cpb_act_q <= cpb_act_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
      fe_q      <= fe_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign data_valid    = ~empty;
  assign read_data     = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign overrun       = overrun_q;
  assign framing_error = fe_q;

endmodule
